// File: rtl/bcd_date_counter.sv
// Calendar date register (day, month, 4-digit year, all BCD) advanced one day per day_tick.
// Uses the external leap-year flag LY to size February.
module bcd_date_counter #(
  parameter logic [15:0] RST_YEAR  = 16'h2000,
  parameter logic [7:0]  RST_MONTH = 8'h01,
  parameter logic [7:0]  RST_DAY   = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        day_tick,
  input  logic        load,
  input  logic [7:0]  ld_day,
  input  logic [7:0]  ld_month,
  input  logic [15:0] ld_year,
  input  logic        LY,
  output logic [3:0]  Ym,
  output logic [3:0]  Yh,
  output logic [3:0]  Yt,
  output logic [3:0]  Yo,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic        month_end,
  output logic        year_end
);

  logic [7:0]  day_q, day_d;
  logic [7:0]  month_q, month_d;
  logic [15:0] year_q, year_d;
  logic        monthEnd_q, monthEnd_d;
  logic        yearEnd_q, yearEnd_d;
  logic [7:0]  lastDay;

  // Returns {carry, digit}; any digit of 9 or above wraps to 0 with a carry.
  function automatic logic [4:0] incDigit(input logic [3:0] d);
    logic [4:0] r;
    if (d >= 4'd9) r = 5'b1_0000;
    else           r = {1'b0, d + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] incBcd8(input logic [7:0] v);
    logic [4:0] lo;
    logic [4:0] hi;
    lo = incDigit(v[3:0]);
    hi = incDigit(v[7:4]);
    return {lo[4] ? hi[3:0] : v[7:4], lo[3:0]};
  endfunction

  function automatic logic [15:0] incBcd16(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    logic [4:0]  dg;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        dg           = incDigit(v[i*4 +: 4]);
        r[i*4 +: 4]  = dg[3:0];
        carry        = dg[4];
      end
    end
    return r;
  endfunction

  always_comb begin
    lastDay = 8'h31;
    case (month_q)
      8'h04, 8'h06, 8'h09, 8'h11: lastDay = 8'h30;
      8'h02:                      lastDay = LY ? 8'h29 : 8'h28;
      default:                    lastDay = 8'h31;
    endcase
  end

  // The >= compares make out-of-range loaded dates roll over on the next tick.
  always_comb begin
    day_d      = day_q;
    month_d    = month_q;
    year_d     = year_q;
    monthEnd_d = 1'b0;
    yearEnd_d  = 1'b0;
    if (load) begin
      day_d   = ld_day;
      month_d = ld_month;
      year_d  = ld_year;
    end else if (day_tick) begin
      if (day_q < lastDay) begin
        day_d = incBcd8(day_q);
      end else begin
        day_d      = 8'h01;
        monthEnd_d = 1'b1;
        if (month_q >= 8'h12) begin
          month_d   = 8'h01;
          yearEnd_d = 1'b1;
          year_d    = incBcd16(year_q);
        end else begin
          month_d = incBcd8(month_q);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_q      <= RST_DAY;
      month_q    <= RST_MONTH;
      year_q     <= RST_YEAR;
      monthEnd_q <= 1'b0;
      yearEnd_q  <= 1'b0;
    end else begin
      day_q      <= day_d;
      month_q    <= month_d;
      year_q     <= year_d;
      monthEnd_q <= monthEnd_d;
      yearEnd_q  <= yearEnd_d;
    end
  end

  assign Ym        = year_q[15:12];
  assign Yh        = year_q[11:8];
  assign Yt        = year_q[7:4];
  assign Yo        = year_q[3:0];
  assign month     = month_q;
  assign day       = day_q;
  assign month_end = monthEnd_q;
  assign year_end  = yearEnd_q;

endmodule

// File: tb/tb_bcd_date_counter.sv
// Bench for bcd_date_counter: integer calendar model checked every cycle, directed
// calendar scenarios pinned with literal dates, then randomized ticks and loads.
module tb_bcd_date_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        day_tick;
  logic        load;
  logic [7:0]  ld_day;
  logic [7:0]  ld_month;
  logic [15:0] ld_year;
  logic        LY;
  logic [3:0]  Ym, Yh, Yt, Yo;
  logic [7:0]  month;
  logic [7:0]  day;
  logic        month_end;
  logic        year_end;

  int errors = 0;
  int checks = 0;

  int mYear, mMonth, mDay;
  bit mMe, mYe;

  int specialYears[6] = '{1900, 2000, 2100, 2024, 9999, 1999};

  always #5 clk = ~clk;

  bcd_date_counter dut (
    .clk(clk), .rst(rst), .day_tick(day_tick), .load(load),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year), .LY(LY),
    .Ym(Ym), .Yh(Yh), .Yt(Yt), .Yo(Yo), .month(month), .day(day),
    .month_end(month_end), .year_end(year_end)
  );

  function automatic int bcdToInt16(input logic [15:0] b);
    return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
  endfunction

  function automatic int bcdToInt8(input logic [7:0] b);
    return b[7:4] * 10 + b[3:0];
  endfunction

  function automatic logic [15:0] intToBcd16(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] intToBcd8(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit isLeap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int daysIn(input int m, input int y);
    case (m)
      4, 6, 9, 11: return 30;
      2:           return isLeap(y) ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  // Stands in for the real leap-year detector wired to the year digit outputs.
  assign LY = isLeap(bcdToInt16({Ym, Yh, Yt, Yo}));

  // Reference calendar in plain integers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mYear = 2000; mMonth = 1; mDay = 1; mMe = 0; mYe = 0;
    end else if (load) begin
      mYear  = bcdToInt16(ld_year);
      mMonth = bcdToInt8(ld_month);
      mDay   = bcdToInt8(ld_day);
      mMe = 0; mYe = 0;
    end else if (day_tick) begin
      mMe = 0; mYe = 0;
      if (mDay < daysIn(mMonth, mYear)) begin
        mDay = mDay + 1;
      end else begin
        mDay = 1;
        mMe  = 1;
        if (mMonth >= 12) begin
          mMonth = 1;
          mYe    = 1;
          mYear  = (mYear + 1) % 10000;
        end else begin
          mMonth = mMonth + 1;
        end
      end
    end else begin
      mMe = 0; mYe = 0;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({Ym, Yh, Yt, Yo} !== intToBcd16(mYear) || month !== intToBcd8(mMonth) ||
        day !== intToBcd8(mDay) || month_end !== mMe || year_end !== mYe) begin
      errors++;
      $display("[TB] FAIL model_compare t=%0t got %h-%h-%h me=%b ye=%b expected %h-%h-%h me=%b ye=%b",
               $time, {Ym, Yh, Yt, Yo}, month, day, month_end, year_end,
               intToBcd16(mYear), intToBcd8(mMonth), intToBcd8(mDay), mMe, mYe);
    end
  end

  task automatic applyStimulus(input bit tick, input bit ld,
                               input logic [15:0] y, input logic [7:0] m, input logic [7:0] d);
    day_tick = tick;
    load     = ld;
    ld_year  = y;
    ld_month = m;
    ld_day   = d;
    @(posedge clk);
    #1;
    day_tick = 1'b0;
    load     = 1'b0;
  endtask

  task automatic tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h0, 8'h0);
  endtask

  task automatic loadDate(input logic [15:0] y, input logic [7:0] m, input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, y, m, d);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] y, input logic [7:0] m,
                             input logic [7:0] d, input bit me, input bit ye);
    checks++;
    if ({Ym, Yh, Yt, Yo} !== y || month !== m || day !== d || month_end !== me || year_end !== ye) begin
      errors++;
      $display("[TB] FAIL %s got %h-%h-%h me=%b ye=%b expected %h-%h-%h me=%b ye=%b",
               name, {Ym, Yh, Yt, Yo}, month, day, month_end, year_end, y, m, d, me, ye);
    end
  endtask

  initial begin
    rst = 1'b1; day_tick = 1'b0; load = 1'b0;
    ld_day = 8'h0; ld_month = 8'h0; ld_year = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_state", 16'h2000, 8'h01, 8'h01, 0, 0);

    for (int i = 0; i < 8; i++) tick();
    checkOutput("jan_09", 16'h2000, 8'h01, 8'h09, 0, 0);
    tick();
    checkOutput("jan_10", 16'h2000, 8'h01, 8'h10, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("jan_30", 16'h2000, 8'h01, 8'h30, 0, 0);
    tick();
    checkOutput("jan_31", 16'h2000, 8'h01, 8'h31, 0, 0);
    tick();
    checkOutput("feb_01", 16'h2000, 8'h02, 8'h01, 1, 0);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
    checkOutput("pulse_clears", 16'h2000, 8'h02, 8'h01, 0, 0);

    loadDate(16'h2024, 8'h02, 8'h28);
    checkOutput("load_2024", 16'h2024, 8'h02, 8'h28, 0, 0);
    tick();
    checkOutput("leap_29", 16'h2024, 8'h02, 8'h29, 0, 0);
    tick();
    checkOutput("leap_mar", 16'h2024, 8'h03, 8'h01, 1, 0);
    loadDate(16'h2023, 8'h02, 8'h28); tick();
    checkOutput("nonleap_mar", 16'h2023, 8'h03, 8'h01, 1, 0);

    loadDate(16'h1900, 8'h02, 8'h28); tick();
    checkOutput("c1900", 16'h1900, 8'h03, 8'h01, 1, 0);
    loadDate(16'h2000, 8'h02, 8'h28); tick();
    checkOutput("c2000", 16'h2000, 8'h02, 8'h29, 0, 0);
    loadDate(16'h2100, 8'h02, 8'h28); tick();
    checkOutput("c2100", 16'h2100, 8'h03, 8'h01, 1, 0);

    loadDate(16'h9999, 8'h12, 8'h31); tick();
    checkOutput("wrap_9999", 16'h0000, 8'h01, 8'h01, 1, 1);
    loadDate(16'h1999, 8'h12, 8'h31); tick();
    checkOutput("ripple_1999", 16'h2000, 8'h01, 8'h01, 1, 1);

    loadDate(16'h2023, 8'h04, 8'h30); tick();
    checkOutput("apr_30", 16'h2023, 8'h05, 8'h01, 1, 0);
    loadDate(16'h2023, 8'h05, 8'h30); tick();
    checkOutput("may_30", 16'h2023, 8'h05, 8'h31, 0, 0);
    loadDate(16'h2023, 8'h09, 8'h30); tick();
    checkOutput("sep_30", 16'h2023, 8'h10, 8'h01, 1, 0);

    loadDate(16'h2022, 8'h05, 8'h31);
    applyStimulus(1'b1, 1'b1, 16'h2022, 8'h06, 8'h15);
    checkOutput("load_beats_tick", 16'h2022, 8'h06, 8'h15, 0, 0);
    loadDate(16'h2022, 8'h02, 8'h31); tick();
    checkOutput("illegal_feb31", 16'h2022, 8'h03, 8'h01, 1, 0);

    loadDate(16'h2022, 8'h07, 8'h31);
    day_tick = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", 16'h2000, 8'h01, 8'h01, 0, 0);
    #1 rst = 1'b0;
    day_tick = 1'b0;
    @(posedge clk); #1;
    checkOutput("after_reset_hold", 16'h2000, 8'h01, 8'h01, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      int y, m, d;
      if ($urandom_range(0, 39) == 0) begin
        y = ($urandom_range(0, 3) == 0) ? specialYears[$urandom_range(0, 5)] : int'($urandom_range(0, 9999));
        m = ($urandom_range(0, 2) == 0) ? 12 : int'($urandom_range(1, 12));
        d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(1, 31));
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, intToBcd16(y), intToBcd8(m), intToBcd8(d));
      end else begin
        applyStimulus(($urandom_range(0, 3) != 0), 1'b0, 16'h0, 8'h0, 8'h0);
      end
    end

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
